// File: rtl/synth_pkg.sv
// Shared definitions for the ADSR envelope: state encoding, level ceiling
// and the default tick divider.
package synth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } adsr_state_e;

    localparam logic [7:0] LEVEL_MAX        = 8'd255;
    localparam int         TICK_DIV_DEFAULT = 1000;

endpackage

// File: rtl/tick_gen.sv
// Free-running divider: one-cycle tick pulse every TICK_DIV clk cycles.
module tick_gen
    import synth_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(TICK_DIV - 1);

    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/envelope_adsr.sv
// ADSR envelope generator: gate-driven level FSM stepping on divided ticks,
// scaling the input sample by level/256 into a registered output.
module envelope_adsr
    import synth_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               gate,
    input  logic signed [15:0] sig_in,
    input  logic [3:0]         attack,
    input  logic [3:0]         decay,
    input  logic [7:0]         sustain,
    // "release" is a reserved word, hence the suffix
    input  logic [3:0]         release_rate,
    output logic signed [15:0] sig_out,
    output logic [7:0]         level,
    output logic               busy
);

    function automatic logic [7:0] level_step(input logic [7:0] lvl, input logic up);
        if (up) begin
            return (lvl == LEVEL_MAX) ? LEVEL_MAX : lvl + 8'd1;
        end
        return (lvl == 8'd0) ? 8'd0 : lvl - 8'd1;
    endfunction

    function automatic logic signed [15:0] scale(input logic signed [15:0] s, input logic [7:0] lvl);
        logic signed [23:0] a;
        logic signed [23:0] b;
        logic signed [23:0] prod;
        a    = {{8{s[15]}}, s};
        b    = {16'd0, lvl};
        prod = a * b;
        return prod[23:8];
    endfunction

    adsr_state_e        state_q, state_d;
    logic [7:0]         level_q, level_d;
    logic [3:0]         step_cnt_q, step_cnt_d;
    logic signed [15:0] sig_out_q, sig_out_d;
    logic               gate_q, gate_d;
    logic               gate_dly_q, gate_dly_d;
    logic               tick, rise, fall, step;
    logic [3:0]         rate;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    always_comb begin
        gate_d     = gate;
        gate_dly_d = gate_q;
        rise       = gate_q & ~gate_dly_q;
        fall       = ~gate_q & gate_dly_q;

        case (state_q)
            ST_ATTACK:  rate = attack;
            ST_DECAY:   rate = decay;
            ST_RELEASE: rate = release_rate;
            default:    rate = 4'd0;
        endcase
        step = tick && (step_cnt_q == rate);

        state_d    = state_q;
        level_d    = level_q;
        step_cnt_d = step_cnt_q;
        sig_out_d  = scale(sig_in, level_q);

        // Gate edges win over any coincident step: no level change that cycle.
        if (rise) begin
            state_d    = ST_ATTACK;
            step_cnt_d = 4'd0;
        end else if (fall && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                              state_q == ST_SUSTAIN)) begin
            state_d    = ST_RELEASE;
            step_cnt_d = 4'd0;
        end else begin
            if (tick) begin
                step_cnt_d = step ? 4'd0 : step_cnt_q + 4'd1;
            end
            case (state_q)
                ST_ATTACK: begin
                    if (step) begin
                        level_d = level_step(level_q, 1'b1);
                        if (level_d == LEVEL_MAX) begin
                            state_d = ST_DECAY;
                        end
                    end
                end
                ST_DECAY: begin
                    // "<=" also releases a decay whose sustain target was raised above it.
                    if (level_q <= sustain) begin
                        state_d    = ST_SUSTAIN;
                        step_cnt_d = 4'd0;
                    end else if (step) begin
                        level_d = level_step(level_q, 1'b0);
                    end
                end
                ST_SUSTAIN: begin
                    level_d    = sustain;
                    step_cnt_d = 4'd0;
                end
                ST_RELEASE: begin
                    if (level_q == 8'd0) begin
                        state_d    = ST_IDLE;
                        step_cnt_d = 4'd0;
                    end else if (step) begin
                        level_d = level_step(level_q, 1'b0);
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    level_d    = 8'd0;
                    step_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            level_q    <= 8'd0;
            step_cnt_q <= 4'd0;
            sig_out_q  <= '0;
            gate_q     <= 1'b0;
            gate_dly_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            level_q    <= level_d;
            step_cnt_q <= step_cnt_d;
            sig_out_q  <= sig_out_d;
            gate_q     <= gate_d;
            gate_dly_q <= gate_dly_d;
        end
    end

    assign sig_out = sig_out_q;
    assign level   = level_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_envelope_adsr.sv
// Directed bench for envelope_adsr: the stimulus process queues expected
// outputs, a monitor process pops and compares them on the falling edge.
module tb_envelope_adsr;

    localparam int TICK_DIV = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               gate;
    logic signed [15:0] sig_in;
    logic [3:0]         attack, decay, release_rate;
    logic [7:0]         sustain;
    logic signed [15:0] sig_out;
    logic [7:0]         level;
    logic               busy;

    always #5 clk = ~clk;

    envelope_adsr #(.TICK_DIV(TICK_DIV)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .gate         (gate),
        .sig_in       (sig_in),
        .attack       (attack),
        .decay        (decay),
        .sustain      (sustain),
        .release_rate (release_rate),
        .sig_out      (sig_out),
        .level        (level),
        .busy         (busy)
    );

    typedef struct packed {
        logic [7:0]  lvl;
        logic [15:0] out;
        logic        bsy;
        logic        chk_out;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic cmp(input string tag, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at %0t",
                     tag, act, act, req, req, $time);
        end
    endtask

    task automatic expect_now(input string tag, input logic [7:0] lvl, input logic [15:0] out,
                              input logic bsy, input logic chk_out);
        exp_t e;
        e.lvl     = lvl;
        e.out     = out;
        e.bsy     = bsy;
        e.chk_out = chk_out;
        exp_q.push_back(e);
        name_q.push_back(tag);
    endtask

    // Monitor: compares queued expectations against the DUT mid-cycle.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp({nm, ".level"}, {24'd0, level}, {24'd0, e.lvl});
                cmp({nm, ".busy"}, {31'd0, busy}, {31'd0, e.bsy});
                if (e.chk_out) begin
                    cmp({nm, ".sig_out"}, {16'd0, sig_out}, {16'd0, e.out});
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_level(input string tag, input logic [7:0] target, input int budget,
                              output int cyc);
        cyc = 0;
        while (level !== target && cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        cmp({tag, ".reached"}, {24'd0, level}, {24'd0, target});
    endtask

    task automatic check_range(input string tag, input int val, input int lo, input int hi);
        vectors++;
        if (val < lo || val > hi) begin
            miscompares++;
            $display("FAIL %s: got %0d cycles, required %0d..%0d", tag, val, lo, hi);
        end
    endtask

    initial begin
        int cyc;

        rst_n        = 1'b0;
        gate         = 1'b0;
        sig_in       = 16'sh0FFF;
        attack       = 4'd0;
        decay        = 4'd0;
        sustain      = 8'd128;
        release_rate = 4'd1;

        // Reset state and idle after release.
        cycles(3);
        expect_now("reset", 8'd0, 16'h0000, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(4);
        expect_now("idle", 8'd0, 16'h0000, 1'b0, 1'b1);

        // Attack to 255, decay to 128, sustain.
        gate = 1'b1;
        wait_level("attack_top", 8'd255, 1200, cyc);
        check_range("attack_time", cyc, 1016, 1024);
        expect_now("attack_peak", 8'd255, 16'h0FDF, 1'b1, 1'b1);
        wait_level("decay_floor", 8'd128, 600, cyc);
        check_range("decay_time", cyc, 504, 512);
        cycles(20);
        expect_now("sustain128", 8'd128, 16'h07FF, 1'b1, 1'b1);
        sustain = 8'd140;
        cycles(2);
        expect_now("sustain_follow", 8'd140, 16'h08BF, 1'b1, 1'b1);
        sustain = 8'd128;
        cycles(2);
        expect_now("sustain_back", 8'd128, 16'h07FF, 1'b1, 1'b1);

        // Release with R=1 down to idle.
        gate = 1'b0;
        wait_level("release_zero", 8'd0, 1200, cyc);
        check_range("release_time", cyc, 1019, 1031);
        expect_now("release_last", 8'd0, 16'h000F, 1'b1, 1'b1);
        cycles(1);
        expect_now("release_idle", 8'd0, 16'h0000, 1'b0, 1'b1);

        // S=255: short decay, sustain at full scale, negative sample.
        sustain = 8'd255;
        sig_in  = 16'shF000;
        gate    = 1'b1;
        wait_level("full_attack", 8'd255, 1200, cyc);
        cycles(1);
        expect_now("full_scale_neg", 8'd255, 16'hF010, 1'b1, 1'b1);
        cycles(50);
        expect_now("s255_hold", 8'd255, 16'hF010, 1'b1, 1'b1);
        release_rate = 4'd0;
        gate = 1'b0;
        wait_level("neg_release", 8'd0, 1200, cyc);
        expect_now("neg_last", 8'd0, 16'hFFF0, 1'b1, 1'b1);
        cycles(1);
        expect_now("neg_idle", 8'd0, 16'h0000, 1'b0, 1'b1);

        // Retrigger during release at level 60.
        sustain = 8'd128;
        sig_in  = 16'sh0FFF;
        gate    = 1'b1;
        wait_level("rt_attack", 8'd255, 1200, cyc);
        wait_level("rt_decay", 8'd128, 600, cyc);
        cycles(4);
        gate = 1'b0;
        wait_level("rt_release60", 8'd60, 600, cyc);
        attack = 4'd1;
        gate   = 1'b1;
        cycles(6);
        expect_now("rt_hold60", 8'd60, 16'h03BF, 1'b1, 1'b1);
        cycles(2);
        expect_now("rt_61", 8'd61, 16'h03BF, 1'b1, 1'b1);
        cycles(8);
        expect_now("rt_62", 8'd62, 16'h0000, 1'b1, 1'b0);

        // Asynchronous reset mid-attack.
        attack = 4'd0;
        wait_level("ra_100", 8'd100, 400, cyc);
        #1;
        rst_n = 1'b0;
        #1;
        expect_now("abort", 8'd0, 16'h0000, 1'b0, 1'b1);
        cycles(3);
        @(negedge clk);
        rst_n = 1'b1;
        cycles(3);
        expect_now("restart", 8'd0, 16'h0000, 1'b1, 1'b1);
        wait_level("restart_1", 8'd1, 8, cyc);
        wait_level("restart_2", 8'd2, 8, cyc);

        cycles(2);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
